// File: rtl/skid_pipe_pkg.sv
// skid_pipe_pkg
// Shared constants and helpers for the skid_pipe register pipeline.
//   MODE_FWD  : forward stage, valid/data registered, ready combinational
//   MODE_BWD  : backward skid stage, ready registered, valid/data pass through
//   MODE_FULL : main + skid entry, valid, data and ready all registered
//   count_width(depth) : width of the occupancy counter for a chain of depth stages
package skid_pipe_pkg;

  localparam int MODE_FWD  = 0;
  localparam int MODE_BWD  = 1;
  localparam int MODE_FULL = 2;

  // Each stage holds at most two beats, so the count spans 0..2*depth.
  function automatic int count_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// skid_stage
// One valid/ready register stage of the skid_pipe chain.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : clears held beats, blocks both handshakes this cycle
//   valid_f/ready_f/data_f : upstream handshake and payload
//   valid_b/ready_b/data_b : downstream handshake and payload
//   occ               : number of beats held in this stage (0..2)
module skid_stage
  import skid_pipe_pkg::*;
#(
  parameter int L    = 8,
  parameter int MODE = MODE_FULL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         valid_f,
  output logic         ready_f,
  input  logic [L-1:0] data_f,
  output logic         valid_b,
  input  logic         ready_b,
  output logic [L-1:0] data_b,
  output logic [1:0]   occ
);

  if (MODE == MODE_FWD) begin : g_fwd
    logic         v;
    logic [L-1:0] d;

    assign ready_f = (!v || ready_b) && !flush;
    assign valid_b = v && !flush;
    assign data_b  = d;
    assign occ     = {1'b0, v};

    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        d <= '0;
      end else if (flush) begin
        v <= 1'b0;
      end else if (valid_f && ready_f) begin
        d <= data_f;
        v <= 1'b1;
      end else if (ready_b) begin
        v <= 1'b0;
      end
    end

  end else if (MODE == MODE_BWD) begin : g_bwd
    logic         sv;
    logic [L-1:0] sd;

    // Ready comes only from the skid register, so the downstream ready path
    // is cut here; an empty stage lets the beat straight through.
    assign ready_f = !sv && !flush;
    assign valid_b = (sv || valid_f) && !flush;
    assign data_b  = sv ? sd : data_f;
    assign occ     = {1'b0, sv};

    always_ff @(posedge clk) begin
      if (rst) begin
        sv <= 1'b0;
        sd <= '0;
      end else if (flush) begin
        sv <= 1'b0;
      end else if (sv) begin
        if (ready_b) sv <= 1'b0;
      end else if (valid_f && !ready_b) begin
        sv <= 1'b1;
        sd <= data_f;
      end
    end

  end else if (MODE == MODE_FULL) begin : g_full
    logic         mv, sv;
    logic [L-1:0] md, sd;
    logic         accept, take;

    assign ready_f = !sv && !flush;
    assign valid_b = mv && !flush;
    assign data_b  = md;
    assign occ     = {1'b0, mv} + {1'b0, sv};
    assign accept  = valid_f && ready_f;
    assign take    = valid_b && ready_b;

    // The skid entry only fills when main is stalled, so a taken main
    // always refills from skid first, keeping beats in arrival order.
    always_ff @(posedge clk) begin
      if (rst) begin
        mv <= 1'b0;
        sv <= 1'b0;
        md <= '0;
        sd <= '0;
      end else if (flush) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (take) begin
        if (sv) begin
          md <= sd;
          sv <= 1'b0;
        end else if (accept) begin
          md <= data_f;
        end else begin
          mv <= 1'b0;
        end
      end else if (accept) begin
        if (!mv) begin
          mv <= 1'b1;
          md <= data_f;
        end else begin
          sv <= 1'b1;
          sd <= data_f;
        end
      end
    end

  end else begin : g_bad_mode
    $error("skid_stage: illegal MODE %0d (expected 0, 1 or 2)", MODE);
  end

endmodule

// File: rtl/skid_pipe.sv
// skid_pipe
// DEPTH cascaded skid_stage instances of one MODE, with flush and a beat count.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   flush                  : synchronous clear of all held beats
//   valid_f/ready_f/data_f : producer side
//   valid_b/ready_b/data_b : consumer side
//   count                  : beats currently held across all stages
module skid_pipe
  import skid_pipe_pkg::*;
#(
  parameter int L     = 8,
  parameter int DEPTH = 2,
  parameter int MODE  = MODE_FULL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          valid_f,
  output logic                          ready_f,
  input  logic [L-1:0]                  data_f,
  output logic                          valid_b,
  input  logic                          ready_b,
  output logic [L-1:0]                  data_b,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  if (DEPTH < 1 || L < 1) begin : g_bad_size
    $error("skid_pipe: DEPTH (%0d) and L (%0d) must both be at least 1", DEPTH, L);
  end

  // Link k is the *_f side of stage k and the *_b side of stage k-1.
  logic         vc  [DEPTH+1];
  logic         rc  [DEPTH+1];
  logic [L-1:0] dc  [DEPTH+1];
  logic [1:0]   occ [DEPTH];

  assign vc[0]     = valid_f;
  assign dc[0]     = data_f;
  assign ready_f   = rc[0];
  assign valid_b   = vc[DEPTH];
  assign data_b    = dc[DEPTH];
  assign rc[DEPTH] = ready_b;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    skid_stage #(
      .L    (L),
      .MODE (MODE)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .valid_f (vc[k]),
      .ready_f (rc[k]),
      .data_f  (dc[k]),
      .valid_b (vc[k+1]),
      .ready_b (rc[k+1]),
      .data_b  (dc[k+1]),
      .occ     (occ[k])
    );
  end

  // Occupancies come straight from stage registers, so the sum tracks
  // the same edge as the transfers.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(occ[i]);
    end
  end

endmodule

// File: tb/tb_skid_pipe.sv
// tb_skid_pipe
// Self-checking bench for skid_pipe: MODE 2/DEPTH 2 (vector table + stream),
// MODE 1/DEPTH 1 (skid corner sequence), MODE 0/DEPTH 3 (random ready_b with
// a scoreboard). Inputs change on the falling edge, outputs are sampled 1ns later.
module tb_skid_pipe;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       vf;
    logic [7:0] df;
    logic       rb;
    logic       vb;
    logic [7:0] db;
    logic       rf;
    logic [2:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // DUT A: MODE 2, DEPTH 2
  logic       rst_a, flush_a, vf_a, rf_a, vb_a, rb_a;
  logic [7:0] df_a, db_a;
  logic [2:0] cnt_a;
  // DUT B: MODE 1, DEPTH 1
  logic       rst_b, flush_b, vf_b, rf_b, vb_b, rb_b;
  logic [7:0] df_b, db_b;
  logic [1:0] cnt_b;
  // DUT C: MODE 0, DEPTH 3
  logic       rst_c, flush_c, vf_c, rf_c, vb_c, rb_c;
  logic [7:0] df_c, db_c;
  logic [2:0] cnt_c;

  skid_pipe #(.L(8), .DEPTH(2), .MODE(2)) u_a (
    .clk(clk), .rst(rst_a), .flush(flush_a), .valid_f(vf_a), .ready_f(rf_a),
    .data_f(df_a), .valid_b(vb_a), .ready_b(rb_a), .data_b(db_a), .count(cnt_a));

  skid_pipe #(.L(8), .DEPTH(1), .MODE(1)) u_b (
    .clk(clk), .rst(rst_b), .flush(flush_b), .valid_f(vf_b), .ready_f(rf_b),
    .data_f(df_b), .valid_b(vb_b), .ready_b(rb_b), .data_b(db_b), .count(cnt_b));

  skid_pipe #(.L(8), .DEPTH(3), .MODE(0)) u_c (
    .clk(clk), .rst(rst_c), .flush(flush_c), .valid_f(vf_c), .ready_f(rf_c),
    .data_f(df_c), .valid_b(vb_c), .ready_b(rb_c), .data_b(db_c), .count(cnt_c));

  vec_t tbl_a [23];
  vec_t tbl_b [7];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic applyStimulus(input vec_t v, input bit to_b);
    if (to_b) begin
      rst_b = v.rst; flush_b = v.flush; vf_b = v.vf; df_b = v.df; rb_b = v.rb;
    end else begin
      rst_a = v.rst; flush_a = v.flush; vf_a = v.vf; df_a = v.df; rb_a = v.rb;
    end
  endtask

  logic [7:0] q[$];
  logic       prev_stall;
  logic [7:0] prev_db;

  // One MODE 0 cycle: model the FIFO order, count and stall stability.
  task automatic stepModeZero(input int i);
    #1;
    checkOutput($sformatf("m0_count_%0d", i), 32'(cnt_c), 32'(q.size()));
    if (prev_stall) begin
      checkOutput($sformatf("m0_hold_valid_%0d", i), 32'(vb_c), 32'(1));
      checkOutput($sformatf("m0_hold_data_%0d", i), 32'(db_c), 32'(prev_db));
    end
    if (vb_c && rb_c) begin
      if (q.size() == 0) checkOutput($sformatf("m0_spurious_%0d", i), 32'(vb_c), 32'(0));
      else checkOutput($sformatf("m0_order_%0d", i), 32'(db_c), 32'(q.pop_front()));
    end
    if (vf_c && rf_c) q.push_back(df_c);
    prev_stall = vb_c && !rb_c;
    prev_db    = db_c;
  endtask

  initial begin
    //           rst   flush vf    df     rb     vb    db     rf    cnt
    tbl_a[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0};
    tbl_a[1]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0};
    tbl_a[2]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl_a[3]  = '{1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 8'h11, 1'b1, 3'd2};
    tbl_a[4]  = '{1'b0, 1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 8'h11, 1'b1, 3'd3};
    tbl_a[5]  = '{1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b1, 8'h11, 1'b0, 3'd4};
    tbl_a[6]  = '{1'b0, 1'b0, 1'b1, 8'h15, 1'b1, 1'b1, 8'h11, 1'b0, 3'd4};
    tbl_a[7]  = '{1'b0, 1'b0, 1'b1, 8'h15, 1'b1, 1'b1, 8'h12, 1'b0, 3'd3};
    tbl_a[8]  = '{1'b0, 1'b0, 1'b1, 8'h15, 1'b1, 1'b1, 8'h13, 1'b1, 3'd2};
    tbl_a[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h14, 1'b1, 3'd2};
    tbl_a[10] = '{1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b1, 8'h15, 1'b1, 3'd1};
    tbl_a[11] = '{1'b0, 1'b0, 1'b1, 8'h17, 1'b0, 1'b1, 8'h15, 1'b1, 3'd2};
    tbl_a[12] = '{1'b0, 1'b1, 1'b1, 8'h18, 1'b1, 1'b0, 8'h15, 1'b0, 3'd3};
    tbl_a[13] = '{1'b0, 1'b0, 1'b1, 8'h18, 1'b1, 1'b0, 8'h15, 1'b1, 3'd0};
    tbl_a[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h15, 1'b1, 3'd1};
    tbl_a[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h18, 1'b1, 3'd1};
    tbl_a[16] = '{1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b0, 8'h18, 1'b1, 3'd0};
    tbl_a[17] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h18, 1'b1, 3'd1};
    tbl_a[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h21, 1'b0, 3'd2};
    tbl_a[19] = '{1'b0, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0};
    tbl_a[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl_a[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h31, 1'b1, 3'd1};
    tbl_a[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h31, 1'b1, 3'd0};

    tbl_b[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0};
    tbl_b[1]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b1, 3'd0};
    tbl_b[2]  = '{1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 8'hAA, 1'b0, 3'd1};
    tbl_b[3]  = '{1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'hAA, 1'b0, 3'd1};
    tbl_b[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hAA, 1'b0, 3'd1};
    tbl_b[5]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 3'd0};
    tbl_b[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0};

    rst_a = 1'b1; flush_a = 1'b0; vf_a = 1'b0; df_a = 8'h00; rb_a = 1'b0;
    rst_b = 1'b1; flush_b = 1'b0; vf_b = 1'b0; df_b = 8'h00; rb_b = 1'b0;
    rst_c = 1'b1; flush_c = 1'b0; vf_c = 1'b0; df_c = 8'h00; rb_c = 1'b0;
    repeat (2) @(posedge clk);

    // MODE 2 vector table: back-pressure fill/drain, flush, reset mid-stream.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      applyStimulus(tbl_a[i], 1'b0);
      #1;
      checkOutput($sformatf("a%0d_valid_b", i), 32'(vb_a),  32'(tbl_a[i].vb));
      checkOutput($sformatf("a%0d_data_b", i),  32'(db_a),  32'(tbl_a[i].db));
      checkOutput($sformatf("a%0d_ready_f", i), 32'(rf_a),  32'(tbl_a[i].rf));
      checkOutput($sformatf("a%0d_count", i),   32'(cnt_a), 32'(tbl_a[i].cnt));
    end

    // MODE 2 sustained stream 0x01..0x10: two-cycle latency, no bubbles.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      vf_a = (i < 16);
      df_a = (i < 16) ? 8'(i + 1) : 8'h00;
      rb_a = 1'b1;
      #1;
      checkOutput($sformatf("stream%0d_valid_b", i), 32'(vb_a), 32'(i >= 2 && i <= 17));
      checkOutput($sformatf("stream%0d_ready_f", i), 32'(rf_a), 32'(1));
      if (i >= 2 && i <= 17)
        checkOutput($sformatf("stream%0d_data_b", i), 32'(db_a), 32'(i - 1));
      if (i >= 2 && i <= 16)
        checkOutput($sformatf("stream%0d_count", i), 32'(cnt_a), 32'(2));
    end

    // MODE 1 skid sequence.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(tbl_b[i], 1'b1);
      #1;
      checkOutput($sformatf("b%0d_valid_b", i), 32'(vb_b),  32'(tbl_b[i].vb));
      checkOutput($sformatf("b%0d_data_b", i),  32'(db_b),  32'(tbl_b[i].db));
      checkOutput($sformatf("b%0d_ready_f", i), 32'(rf_b),  32'(tbl_b[i].rf));
      checkOutput($sformatf("b%0d_count", i),   32'(cnt_b), 32'(tbl_b[i].cnt));
    end

    // MODE 0 random ready_b with scoreboard, then a bounded drain.
    @(negedge clk);
    rst_c = 1'b0;
    prev_stall = 1'b0;
    prev_db    = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!(vf_c && !rf_c)) begin
        vf_c = 1'($urandom_range(0, 1));
        df_c = 8'($urandom_range(0, 255));
      end
      rb_c = 1'($urandom_range(0, 1));
      stepModeZero(i);
    end
    for (int i = 0; i < 30 && (q.size() != 0 || vb_c); i++) begin
      @(negedge clk);
      if (!(vf_c && !rf_c)) vf_c = 1'b0;
      rb_c = 1'b1;
      stepModeZero(200 + i);
    end
    checkOutput("m0_drain_left", 32'(q.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/skid_pipe.md
# skid_pipe

Parametrised multi-stage valid/ready register pipeline that generalises the single backward skid stage. It provides width L, DEPTH cascaded stages and a selectable MODE: forward register, backward skid, or full (both paths registered). It also adds a synchronous flush and an occupancy count. It sits between any producer (`*_f` side) and consumer (`*_b` side) to break long valid, data and/or ready timing paths without losing throughput.

## Interface
Parameters:
- `L`, 8, payload width in bits (≥1)
- `DEPTH`, 2, number of cascaded stages (≥1)
- `MODE`, 2, per-stage type: 0 = forward (valid/data registered), 1 = backward (ready registered, skid), 2 = full (valid, data and ready registered)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous clear of all held beats
- `valid_f`  in  1  upstream beat valid
- `ready_f`  out  1  pipeline can accept upstream beat
- `data_f`  in  L  upstream payload
- `valid_b`  out  1  downstream beat valid
- `ready_b`  in  1  downstream accepts
- `data_b`  out  L  downstream payload
- `count`  out  $clog2(2*DEPTH+1)  number of beats currently held

## Operation
- Transfer occurs on a side when valid and ready are both high at a rising edge. Beats leave in arrival order; none are duplicated or dropped, except by `rst` or `flush`.
- Stages are chained: the `*_b` side of stage k drives the `*_f` side of stage k+1.
- MODE 0 stage: one entry `{v,d}`.
  - `ready_f = !v || ready_b` (combinational ready path).
  - On accept: `d <= data_f`, `v <= 1`.
  - On output taken with no accept: `v <= 0`.
- MODE 1 stage: one skid entry `{sv,sd}`.
  - `ready_f = !sv` (registered).
  - `valid_b = sv || valid_f`.
  - `data_b = sv ? sd : data_f`.
  - Beat accepted while `!ready_b` and `!sv` loads skid: `sv <= 1`.
  - `ready_b && sv` clears `sv`.
- MODE 2 stage: main entry `{mv,md}` plus skid `{sv,sd}`.
  - `ready_f = !sv`, `valid_b = mv`, `data_b = md`.
  - Accept when main is empty or being taken: load main.
  - Accept while main is held and not taken: load skid.
  - Main taken while skid is valid: `main <= skid`, `sv <= 0`.
- `count` = number of valid entries across all stages. Its range is 0..DEPTH for MODE 0/1 and 0..2·DEPTH for MODE 2.
- `flush`:
  - Clears every valid bit at the next edge; data registers are not cleared.
  - Forces `ready_f = 0` and `valid_b = 0` combinationally during the flush cycle, so no transfer occurs on either side in that cycle.
  - `flush` and `valid_f` in the same cycle: the beat is not accepted; the producer must hold it.
- `rst` dominates `flush`.

## Timing
- Reset values: `valid_b = 0`, `data_b = 0`, `ready_f = 1`, `count = 0`, all internal valid and data registers 0.
- First cycle after `rst` deasserts: the pipeline accepts.
- Reset asserted mid-stream: all held beats are discarded; no partial output follows.
- Latency from `valid_f` accepted to `valid_b` high, with no back-pressure:
  - MODE 0: DEPTH cycles.
  - MODE 1: 0 cycles (combinational).
  - MODE 2: DEPTH cycles.
- Throughput: 1 beat per cycle sustained in all modes while `ready_b = 1`.
- Stability: while `valid_b && !ready_b`, `valid_b` and `data_b` hold unchanged until taken or flushed.
- Back-pressure propagation to `ready_f`:
  - MODE 1/2: ≥1 cycle per stage; `ready_f` depends only on registers and `flush`.
  - MODE 0: combinational through all stages.
- Full: `ready_f = 0` only when stage 0's skid is occupied (MODE 1/2) or the whole chain is full and stalled (MODE 0).
- Empty: `valid_b = 0`, except in MODE 1, where `valid_f` passes through.
- `count` is registered. It updates on the same edge as the transfers and is correct under a simultaneous accept and drain (unchanged value).

## Structure
- Package `skid_pipe_pkg`: `MODE_FWD = 0`, `MODE_BWD = 1`, `MODE_FULL = 2` constants and a count-width function.
- Sub-module `skid_stage` (params `L`, `MODE`): a single stage with the same `*_f`/`*_b` ports plus `flush` and a per-stage occupancy output.
- Top: a generate loop instantiates DEPTH copies, wires the chain and sums occupancies into `count`.
- An illegal MODE is caught by an elaboration-time check.

## Test plan
- MODE 2, DEPTH 2, `ready_b = 1`, beats 0x01..0x10 on consecutive cycles → `data_b` delivers 0x01..0x10 in order, first beat 2 cycles after its accept, no bubbles, `count` stays 2.
- MODE 2, DEPTH 2, `ready_b = 0` while streaming → `ready_f` falls after 4 beats accepted, `count = 4`; when `ready_b` rises, the 4 beats drain in order with none lost.
- MODE 1, DEPTH 1: `valid_f = 1` with 0xAA while `ready_b = 0` → skid loads, `ready_f = 0` next cycle, `data_b = 0xAA` held; `ready_b = 1` → 0xAA taken, `ready_f = 1`.
- MODE 0, DEPTH 3: toggle `ready_b` randomly for 200 cycles → the output sequence equals the input sequence and `data_b` is stable whenever stalled.
- Any mode: `flush` pulse with `count = 3` and `valid_f = 1` → no transfer that cycle, then `count = 0`, `valid_b = 0`, and the pending input is accepted next cycle.
- `rst` asserted mid-stream → next cycle all outputs at reset values and `count = 0`; afterwards only newly sent beats appear.
